// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Watches a multiplexed four-digit seven-segment display bus and rebuilds the
// 16-bit hex value, decimal points and per-digit glyph health being shown.
// Each digit must hold steady for STABLE_CYCLES samples before it is captured.
// A frame is published once all four digits have been captured.
//
// Optional feature macro: SEG_DOT_CAPTURE_EN
//   defined     - the dot bit seg[0] takes part in the stability compare and
//                 is stored to dp
//   not defined - seg[0] is masked off before the sample register and dp
//                 stays 4'b0000
//
// Parameters:
//   STABLE_CYCLES  : identical valid samples needed per capture (1..255)
//   TIMEOUT_CYCLES : idle cycles before a partial frame is dropped (2..2^24-1)
//
// Ports:
//   clk         in   rising-edge system clock
//   reset       in   synchronous, active-high
//   an[3:0]     in   active-low anode strobes, bit 0 = rightmost digit
//   seg[7:0]    in   active-high segments, bits 7..0 = A,B,C,D,E,F,G,dot
//   value[15:0] out  last complete frame, digit 3 in [15:12]
//   dp[3:0]     out  dot bits of the last complete frame
//   bad_mask    out  per-digit blank / non-hex glyph flag
//   frame_valid out  one-cycle pulse when value/dp/bad_mask update
//   err         out  sticky invalid-glyph flag, cleared only by reset
//   stale       out  set by a timeout, cleared by the next frame_valid
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [7:0]  seg,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic [3:0]  bad_mask,
  output logic        frame_valid,
  output logic        err,
  output logic        stale
);

  localparam logic [7:0]  STABLE_C  = 8'(STABLE_CYCLES);
  localparam logic [23:0] TO_LAST_C = 24'(TIMEOUT_CYCLES - 1);

`ifdef SEG_DOT_CAPTURE_EN
  localparam logic [7:0] SEG_KEEP_C = 8'hFF;
  localparam logic [3:0] DP_KEEP_C  = 4'hF;
`else
  localparam logic [7:0] SEG_KEEP_C = 8'hFE;
  localparam logic [3:0] DP_KEEP_C  = 4'h0;
`endif

  // Glyph decode of seg[7:1]; result is {blank, invalid, nibble}.
  function automatic logic [5:0] decode_glyph(input logic [6:0] code);
    case (code)
      7'h7E:   decode_glyph = {2'b00, 4'h0};
      7'h30:   decode_glyph = {2'b00, 4'h1};
      7'h6D:   decode_glyph = {2'b00, 4'h2};
      7'h79:   decode_glyph = {2'b00, 4'h3};
      7'h33:   decode_glyph = {2'b00, 4'h4};
      7'h5B:   decode_glyph = {2'b00, 4'h5};
      7'h5F:   decode_glyph = {2'b00, 4'h6};
      7'h70:   decode_glyph = {2'b00, 4'h7};
      7'h7F:   decode_glyph = {2'b00, 4'h8};
      7'h73:   decode_glyph = {2'b00, 4'h9};
      7'h77:   decode_glyph = {2'b00, 4'hA};
      7'h1F:   decode_glyph = {2'b00, 4'hB};
      7'h4E:   decode_glyph = {2'b00, 4'hC};
      7'h3D:   decode_glyph = {2'b00, 4'hD};
      7'h4F:   decode_glyph = {2'b00, 4'hE};
      7'h47:   decode_glyph = {2'b00, 4'hF};
      7'h00:   decode_glyph = {2'b10, 4'h0};
      default: decode_glyph = {2'b01, 4'h0};
    endcase
  endfunction

  logic [3:0]  an_q, an_d, prev_an_q, prev_an_d;
  logic [7:0]  seg_q, seg_d, prev_seg_q, prev_seg_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic [15:0] pend_val_q, pend_val_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic [3:0]  pend_bad_q, pend_bad_d;
  logic [3:0]  seen_q, seen_d;
  logic [23:0] to_q, to_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  dp_q, dp_d;
  logic [3:0]  bad_q, bad_d;
  logic        fv_q, fv_d;
  logic        err_q, err_d;
  logic        stale_q, stale_d;

  logic        sample_chg_s;
  logic        digit_ok_s;
  logic [1:0]  digit_idx_s;
  logic        armed_eff_s;
  logic        capture_s;
  logic [5:0]  glyph_s;

  // Input stage: register the bus (dot masked when not captured) and keep the
  // previous sample for the stability compare.
  always_comb begin
    an_d       = an;
    seg_d      = seg & SEG_KEEP_C;
    prev_an_d  = an_q;
    prev_seg_d = seg_q;
  end

  // Stability counter and single-shot capture qualification.
  always_comb begin
    sample_chg_s = (an_q != prev_an_q) || (seg_q != prev_seg_q);
    digit_ok_s   = 1'b1;
    digit_idx_s  = 2'd0;
    case (an_q)
      4'b1110: digit_idx_s = 2'd0;
      4'b1101: digit_idx_s = 2'd1;
      4'b1011: digit_idx_s = 2'd2;
      4'b0111: digit_idx_s = 2'd3;
      default: digit_ok_s  = 1'b0;
    endcase

    if (!digit_ok_s) begin
      cnt_d = 8'd0;
    end else if (sample_chg_s) begin
      cnt_d = 8'd1;
    end else if (cnt_q == STABLE_C) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end

    // A change re-arms in the same cycle so STABLE_CYCLES=1 captures at once.
    armed_eff_s = sample_chg_s | armed_q;
    capture_s   = digit_ok_s && (cnt_d == STABLE_C) && armed_eff_s;
    armed_d     = capture_s ? 1'b0 : armed_eff_s;
  end

  // Pending digit store, frame assembly, timeout and published outputs.
  always_comb begin
    glyph_s    = decode_glyph(seg_q[7:1]);
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_bad_d = pend_bad_q;
    seen_d     = seen_q;
    to_d       = to_q;
    value_d    = value_q;
    dp_d       = dp_q;
    bad_d      = bad_q;
    fv_d       = 1'b0;
    err_d      = err_q;
    stale_d    = stale_q;

    if (capture_s) begin
      // Blank and invalid glyphs both store a zero nibble (decode gives 0).
      pend_val_d[{digit_idx_s, 2'b00} +: 4] = glyph_s[3:0];
      pend_dp_d[digit_idx_s]  = seg_q[0];
      pend_bad_d[digit_idx_s] = glyph_s[5] | glyph_s[4];
      seen_d[digit_idx_s]     = 1'b1;
      to_d                    = 24'd0;
      if (glyph_s[4]) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
      if (seen_d == 4'hF) begin
        value_d = pend_val_d;
        dp_d    = pend_dp_d & DP_KEEP_C;
        bad_d   = pend_bad_d;
        fv_d    = 1'b1;
        seen_d  = 4'h0;
        stale_d = 1'b0;
      end else begin
        fv_d    = 1'b0;
      end
    end else if (to_q == TO_LAST_C) begin
      // Timeout drops the partial frame but keeps the published outputs.
      to_d    = 24'd0;
      seen_d  = 4'h0;
      stale_d = 1'b1;
    end else begin
      to_d    = to_q + 24'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q       <= 4'hF;
      seg_q      <= 8'h00;
      prev_an_q  <= 4'hF;
      prev_seg_q <= 8'h00;
      cnt_q      <= 8'd0;
      armed_q    <= 1'b1;
      pend_val_q <= 16'h0000;
      pend_dp_q  <= 4'h0;
      pend_bad_q <= 4'h0;
      seen_q     <= 4'h0;
      to_q       <= 24'd0;
      value_q    <= 16'h0000;
      dp_q       <= 4'h0;
      bad_q      <= 4'h0;
      fv_q       <= 1'b0;
      err_q      <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      an_q       <= an_d;
      seg_q      <= seg_d;
      prev_an_q  <= prev_an_d;
      prev_seg_q <= prev_seg_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_bad_q <= pend_bad_d;
      seen_q     <= seen_d;
      to_q       <= to_d;
      value_q    <= value_d;
      dp_q       <= dp_d;
      bad_q      <= bad_d;
      fv_q       <= fv_d;
      err_q      <= err_d;
      stale_q    <= stale_d;
    end
  end

  assign value       = value_q;
  assign dp          = dp_q;
  assign bad_mask    = bad_q;
  assign frame_valid = fv_q;
  assign err         = err_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus a random
// scan phase, all compared against a run-length reference model of the bus.
module tb_seg_scan_decoder;

  localparam int unsigned S = 4;
  localparam int unsigned T = 50;
`ifdef SEG_DOT_CAPTURE_EN
  localparam logic [7:0] SEG_KEEP = 8'hFF;
  localparam logic [3:0] DOT_EXP  = 4'b1001;
`else
  localparam logic [7:0] SEG_KEEP = 8'hFE;
  localparam logic [3:0] DOT_EXP  = 4'b0000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  bad_mask;
  logic        frame_valid;
  logic        err;
  logic        stale;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned fv_count = 0;
  logic [6:0]  glyph_tab [16];

  // Reference model state
  int unsigned run_len;
  logic [3:0]  last_an;
  logic [7:0]  last_seg;
  bit          cap_pend;
  logic [3:0]  cap_an;
  logic [7:0]  cap_seg;
  logic [3:0]  m_pv [4];
  logic [3:0]  m_pdp, m_pbad, m_seen;
  logic [15:0] m_value;
  logic [3:0]  m_dp, m_bad;
  logic        m_fv, m_err, m_stale;
  int unsigned m_idle;

  seg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .an(an), .seg(seg), .value(value), .dp(dp),
    .bad_mask(bad_mask), .frame_valid(frame_valid), .err(err), .stale(stale)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    run_len = 0; last_an = 4'hF; last_seg = 8'h00; cap_pend = 1'b0;
    for (int i = 0; i < 4; i++) m_pv[i] = 4'h0;
    m_pdp = 4'h0; m_pbad = 4'h0; m_seen = 4'h0;
    m_value = 16'h0; m_dp = 4'h0; m_bad = 4'h0;
    m_fv = 1'b0; m_err = 1'b0; m_stale = 1'b0; m_idle = 0;
  endtask

  // One clock edge of the model; (a, s) is the bus value sampled at this edge.
  task automatic model_edge(input logic [3:0] a, input logic [7:0] s);
    logic [7:0] sm;
    int         d;
    logic [3:0] nib;
    bit         blank, inval;
    sm   = s & SEG_KEEP;
    m_fv = 1'b0;
    if (cap_pend) begin
      d = 0;
      for (int i = 0; i < 4; i++) if (cap_an[i] == 1'b0) d = i;
      nib = 4'h0; blank = (cap_seg[7:1] == 7'h00); inval = 1'b1;
      for (int i = 0; i < 16; i++) if (glyph_tab[i] == cap_seg[7:1]) begin nib = 4'(i); inval = 1'b0; end
      if (blank) inval = 1'b0;
      m_pv[d] = nib; m_pdp[d] = cap_seg[0]; m_pbad[d] = blank | inval;
      if (inval) m_err = 1'b1;
      m_seen[d] = 1'b1; m_idle = 0;
      if (m_seen == 4'hF) begin
        m_value = {m_pv[3], m_pv[2], m_pv[1], m_pv[0]};
        m_dp = m_pdp; m_bad = m_pbad; m_fv = 1'b1; m_seen = 4'h0; m_stale = 1'b0;
      end
    end else begin
      m_idle++;
      if (m_idle == T) begin m_seen = 4'h0; m_stale = 1'b1; m_idle = 0; end
    end
    cap_pend = 1'b0;
    if ($countones(~a) != 1) run_len = 0;
    else if (a == last_an && sm == last_seg) run_len++;
    else run_len = 1;
    last_an = a; last_seg = sm;
    if (run_len == S) begin cap_pend = 1'b1; cap_an = a; cap_seg = sm; end
  endtask

  task automatic cyc(input logic [3:0] a, input logic [7:0] s);
    an = a; seg = s;
    @(posedge clk);
    model_edge(a, s);
    #1;
    if (frame_valid === 1'b1) fv_count++;
    chk("frame_valid", {31'd0, frame_valid}, {31'd0, m_fv});
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("stale", {31'd0, stale}, {31'd0, m_stale});
    if (m_fv) begin
      chk("value", {16'd0, value}, {16'd0, m_value});
      chk("dp", {28'd0, dp}, {28'd0, m_dp});
      chk("bad_mask", {28'd0, bad_mask}, {28'd0, m_bad});
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic scan_digit(input int d, input logic [6:0] code, input logic dot,
                            input int dwell, input int gap);
    logic [3:0] a;
    a = 4'b0001 << d;
    a = ~a;
    for (int k = 0; k < dwell; k++) cyc(a, {code, dot});
    for (int k = 0; k < gap; k++) cyc(4'hF, 8'h00);
  endtask

  task automatic scan_value(input logic [15:0] v, input logic [3:0] dots);
    for (int d = 3; d >= 0; d--) scan_digit(d, glyph_tab[v[d*4 +: 4]], dots[d], 8, 2);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_value"}, {16'd0, value}, 32'd0);
    chk({tag, "_dp"}, {28'd0, dp}, 32'd0);
    chk({tag, "_bad"}, {28'd0, bad_mask}, 32'd0);
    chk({tag, "_fv"}, {31'd0, frame_valid}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_stale"}, {31'd0, stale}, 32'd0);
  endtask

  initial begin
    logic [3:0] ra;
    logic [6:0] rc;
    int         rr;
    glyph_tab[0]  = 7'h7E; glyph_tab[1]  = 7'h30; glyph_tab[2]  = 7'h6D; glyph_tab[3]  = 7'h79;
    glyph_tab[4]  = 7'h33; glyph_tab[5]  = 7'h5B; glyph_tab[6]  = 7'h5F; glyph_tab[7]  = 7'h70;
    glyph_tab[8]  = 7'h7F; glyph_tab[9]  = 7'h73; glyph_tab[10] = 7'h77; glyph_tab[11] = 7'h1F;
    glyph_tab[12] = 7'h4E; glyph_tab[13] = 7'h3D; glyph_tab[14] = 7'h4F; glyph_tab[15] = 7'h47;
    an = 4'hF; seg = 8'h00;
    model_reset();
    do_reset();
    chk_reset_state("rst");

    // Basic frame 0x1A2F
    fv_count = 0;
    scan_value(16'h1A2F, 4'h0);
    chk("t1_frames", fv_count, 32'd1);
    chk("t1_value", {16'd0, value}, 32'h1A2F);
    chk("t1_bad", {28'd0, bad_mask}, 32'd0);
    chk("t1_err", {31'd0, err}, 32'd0);

    // Glitch on digit 1: '1' for 3 cycles then '2' for 6, no gap
    fv_count = 0;
    scan_digit(3, glyph_tab[12], 1'b0, 8, 2);
    scan_digit(2, glyph_tab[0], 1'b0, 8, 2);
    scan_digit(1, glyph_tab[1], 1'b0, 3, 0);
    scan_digit(1, glyph_tab[2], 1'b0, 6, 2);
    scan_digit(0, glyph_tab[7], 1'b0, 8, 2);
    chk("t2_frames", fv_count, 32'd1);
    chk("t2_value", {16'd0, value}, 32'hC027);

    // Invalid glyph on digit 2, then a clean frame
    fv_count = 0;
    scan_digit(3, glyph_tab[5], 1'b0, 8, 2);
    scan_digit(2, 7'h01, 1'b0, 8, 2);
    scan_digit(1, glyph_tab[9], 1'b0, 8, 2);
    scan_digit(0, glyph_tab[8], 1'b0, 8, 2);
    chk("t3_value", {16'd0, value}, 32'h5098);
    chk("t3_bad", {28'd0, bad_mask}, 32'h4);
    chk("t3_err", {31'd0, err}, 32'd1);
    scan_value(16'h1234, 4'h0);
    chk("t3_err_sticky", {31'd0, err}, 32'd1);
    chk("t3_bad_clean", {28'd0, bad_mask}, 32'd0);

    // Partial frame then timeout
    fv_count = 0;
    for (int d = 2; d >= 0; d--) scan_digit(d, glyph_tab[d + 1], 1'b0, 8, 2);
    repeat (60) cyc(4'hF, 8'h00);
    chk("t4_stale", {31'd0, stale}, 32'd1);
    chk("t4_frames", fv_count, 32'd0);
    chk("t4_value", {16'd0, value}, 32'h1234);
    scan_value(16'h4321, 4'h0);
    chk("t4_frames2", fv_count, 32'd1);
    chk("t4_stale2", {31'd0, stale}, 32'd0);

    // Dots on digits 0 and 3
    scan_value(16'h9876, 4'b1001);
    chk("t5_dp", {28'd0, dp}, {28'd0, DOT_EXP});
    chk("t5_value", {16'd0, value}, 32'h9876);

    // Reset mid-frame after three captures
    for (int d = 3; d >= 1; d--) scan_digit(d, glyph_tab[1], 1'b0, 8, 2);
    cyc(4'b1110, {glyph_tab[1], 1'b0});
    cyc(4'b1110, {glyph_tab[1], 1'b0});
    do_reset();
    chk_reset_state("t6_rst");
    fv_count = 0;
    scan_value(16'hBEEF, 4'h0);
    chk("t6_frames", fv_count, 32'd1);
    chk("t6_value", {16'd0, value}, 32'hBEEF);

    // Random scanning against the model
    for (int i = 0; i < 120; i++) begin
      rr = int'($urandom_range(0, 99));
      ra = 4'b0001 << (3 - (i % 4));
      ra = ~ra;
      if (rr < 10) ra = 4'($urandom_range(0, 15));
      rr = int'($urandom_range(0, 99));
      if (rr < 75) rc = glyph_tab[$urandom_range(0, 15)];
      else if (rr < 85) rc = 7'h00;
      else rc = 7'($urandom);
      rr = int'($urandom_range(1, 10));
      for (int k = 0; k < rr; k++) cyc(ra, {rc, 1'($urandom)});
      rr = int'($urandom_range(0, 3));
      for (int k = 0; k < rr; k++) cyc(4'hF, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the hex-to-seven-segment encoder. Monitors the multiplexed four-digit display bus (active-low anode strobes plus the A..G/dot segment byte) and reconstructs the 16-bit hex value and decimal points being shown. Includes stability filtering, invalid-glyph detection and frame assembly. Sits beside the display driver as a self-check and loopback monitor; it feeds the lab's checker logic and keyboard-echo compare.

## Interface
Parameters:
- STABLE_CYCLES, 4, consecutive identical valid samples required before a digit is captured (legal range 1..255)
- TIMEOUT_CYCLES, 100000, cycles without any capture before the partial frame is discarded (legal range 2..2^24-1)

Ports:
- clk  in  1  system clock; all logic is rising-edge
- reset  in  1  synchronous, active-high; one clock, one reset, no other clock domains
- an  in  4  anode strobes, active-low; exactly one bit low means that digit is lit (bit 0 is the rightmost digit)
- seg  in  8  segment byte, active-high; bit 7..0 = A,B,C,D,E,F,G,dot
- value  out  16  last complete frame, digit 3 in [15:12] down to digit 0 in [3:0]
- dp  out  4  dot bits of the last complete frame
- bad_mask  out  4  per-digit flag: that digit's glyph was blank or not a hex glyph
- frame_valid  out  1  one-cycle pulse when value, dp and bad_mask update
- err  out  1  sticky; set by any invalid glyph capture, cleared only by reset
- stale  out  1  high after a timeout; cleared by the next frame_valid

## Operation
- Input stage: `an` and `seg` are registered every cycle into a sample register. A sample is valid only if `an` has exactly one zero bit; zero or several low bits are a blanking interval.
- Stability counter: reloads to 1 when the sample differs from the previous sample; otherwise it increments, saturating at STABLE_CYCLES. An invalid sample forces the counter to 0.
- Capture: occurs when the counter equals STABLE_CYCLES and the `armed` flag is set. A capture clears `armed`. Any sample change re-sets `armed`, so each digit dwell yields exactly one capture.
- Decode of seg[7:1]:
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 73→9, 77→A, 1F→B, 4E→C, 3D→D, 4F→E, 47→F.
  - 00 is blank. Any other code is invalid.
  - Blank and invalid glyphs store nibble 0 and set the digit's bad bit. Invalid (not blank) also sets `err`.
- Each capture writes the pending nibble, dot and bad bit for the strobed digit and sets its bit in the `seen` mask. Recapturing a digit overwrites it.
- Frame completion: on the capture that makes `seen` equal 4'b1111:
  - pending registers (including the current capture) copy to value/dp/bad_mask;
  - frame_valid pulses;
  - `seen` clears;
  - `stale` clears.
- Timeout counter: cleared on every capture and by reset, otherwise increments. On reaching TIMEOUT_CYCLES it clears `seen`, sets `stale` and restarts from 0. Published outputs are held.

## Timing
- Reset values: value=0, dp=0, bad_mask=0, frame_valid=0, err=0, stale=0. Internally seen=0, armed=1, counters 0, sample register = an 4'hF, seg 0.
- Latency: an input first presented before edge N and held stable updates the pending digit at edge N+STABLE_CYCLES. If that capture completes a frame, the outputs and the frame_valid pulse appear at the same edge.
- frame_valid is high for exactly one cycle, never two in consecutive cycles (armed rule).
- Capture and timeout terminal count in the same cycle: the capture wins; the timeout counter clears and stale is unchanged.
- Reset mid-dwell or mid-frame: all state is discarded. The first capture after reset needs a full STABLE_CYCLES of stable input.
- A digit change with no blanking gap (anode moves directly) reloads the counter to 1, which is legal.

## Configuration
- SEG_DOT_CAPTURE_EN defined: the dot bit (seg[0]) takes part in the stability compare and is stored to `dp`.
- SEG_DOT_CAPTURE_EN not defined: seg[0] is ignored everywhere (masked before the sample register) and `dp` is tied to 4'b0000.

## Test plan
- Reset, then scan digits 3..0 showing 0x1A2F, 8 cycles per digit, 2-cycle blank gap between digits, STABLE_CYCLES=4 → value=16'h1A2F, bad_mask=0, a single frame_valid pulse at the digit-0 capture edge, err=0.
- Glitch: digit 1 shows 0x30 for 3 cycles then 0x6D for 6 cycles → nibble 2 captured and 1 is never captured.
- Invalid glyph 0x01 on digit 2 within an otherwise valid frame → bad_mask=4'b0100, value[11:8]=0, err=1 and still 1 after the next clean frame.
- Only digits 0..2 scanned, then an=4'hF held for TIMEOUT_CYCLES (set to 50) → stale=1, no frame_valid, value unchanged. A subsequent full scan → frame_valid, stale=0.
- Dots set on digits 0 and 3 → dp=4'b1001 with SEG_DOT_CAPTURE_EN, dp=0 without.
- Reset asserted mid-frame after 3 captures, then a full scan of 0xBEEF → exactly one frame_valid, value=16'hBEEF.
